// File: rtl/sd_sqrt_scheduler.sv
// rtl/sd_sqrt_scheduler.sv - round-robin scheduler sharing one iterative sqrt unit among N requesters
module sd_sqrt_scheduler #(
  parameter int WIDTH   = 8,
  parameter int N_REQ   = 4,
  parameter int ID_W    = $clog2(N_REQ),
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   sq_start,
  output logic [WIDTH-1:0]       sq_rad,
  input  logic                   sq_busy,
  input  logic                   sq_valid,
  input  logic [WIDTH-1:0]       sq_root,
  input  logic [WIDTH-1:0]       sq_rem,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_root,
  output logic [WIDTH-1:0]       rsp_rem,
  output logic                   rsp_err
);

  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t           state_q;
  state_t           state_d;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  id_q;
  logic [WIDTH-1:0] rad_q;
  logic [WIDTH-1:0] root_q;
  logic [WIDTH-1:0] rem_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;

  logic             grant_hit;
  logic [ID_W-1:0]  grant_id;
  logic [WIDTH-1:0] grant_data;
  logic             timeout_hit;

  // sq_busy is informational only; sequencing relies on start/valid alone
  logic unused_busy;
  assign unused_busy = sq_busy;

  // Round-robin search: first valid requester at or above rr_ptr, wrapping around
  always_comb begin
    int idx;
    idx        = 0;
    grant_hit  = 1'b0;
    grant_id   = '0;
    grant_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!grant_hit && req_valid[idx]) begin
        grant_hit  = 1'b1;
        grant_id   = ID_W'(idx);
        grant_data = req_data[idx*WIDTH +: WIDTH];
      end
    end
  end

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state: accept -> start pulse -> wait for result or timeout -> hold response
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_hit) state_d = START;
      START:   state_d = WAIT;
      WAIT:    if (sq_valid || timeout_hit) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: latch the accepted radicand, count WAIT cycles, capture result, advance pointer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
      id_q   <= '0;
      rad_q  <= '0;
      root_q <= '0;
      rem_q  <= '0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_hit) begin
            rad_q <= grant_data;
            id_q  <= grant_id;
          end
        end
        START: cnt_q <= '0;
        WAIT: begin
          // a result arriving on the terminal count still counts as success
          if (sq_valid) begin
            root_q <= sq_root;
            rem_q  <= sq_rem;
            err_q  <= 1'b0;
          end else if (timeout_hit) begin
            root_q <= '0;
            rem_q  <= '0;
            err_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) rr_ptr <= (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + ID_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign req_ready = (reset_n && state_q == IDLE && grant_hit) ? (N_REQ'(1) << grant_id) : '0;
  assign sq_start  = (state_q == START);
  assign sq_rad    = rad_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = id_q;
  assign rsp_root  = root_q;
  assign rsp_rem   = rem_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_sd_sqrt_scheduler.sv
// tb/tb_sd_sqrt_scheduler.sv - scoreboard bench for sd_sqrt_scheduler with a sqrt stub and random traffic
module tb_sd_sqrt_scheduler;
  localparam int WIDTH   = 8;
  localparam int N_REQ   = 4;
  localparam int ID_W    = 2;
  localparam int TIMEOUT = 16;

  logic                   clk = 1'b0;
  logic                   reset_n = 1'b0;
  logic [N_REQ-1:0]       req_valid = '0;
  logic [N_REQ*WIDTH-1:0] req_data = '0;
  logic [N_REQ-1:0]       req_ready;
  logic                   sq_start;
  logic [WIDTH-1:0]       sq_rad;
  logic                   sq_busy = 1'b0;
  logic                   sq_valid = 1'b0;
  logic [WIDTH-1:0]       sq_root = '0;
  logic [WIDTH-1:0]       sq_rem = '0;
  logic                   rsp_valid;
  logic                   rsp_ready = 1'b1;
  logic [ID_W-1:0]        rsp_id;
  logic [WIDTH-1:0]       rsp_root;
  logic [WIDTH-1:0]       rsp_rem;
  logic                   rsp_err;

  sd_sqrt_scheduler #(.WIDTH(WIDTH), .N_REQ(N_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .sq_start(sq_start), .sq_rad(sq_rad), .sq_busy(sq_busy), .sq_valid(sq_valid),
    .sq_root(sq_root), .sq_rem(sq_rem),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_root(rsp_root), .rsp_rem(rsp_rem), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int id;
    int root;
    int rem;
    int err;
    int acc_cyc;
    int lat;
  } exp_t;

  // monitor-owned state
  exp_t             exp_q[$];
  int               n_checks = 0;
  int               n_errors = 0;
  bit               busy = 1'b0;
  bit               start_due = 1'b0;
  bit               rsp_seen = 1'b0;
  int               acc_cyc = 0;
  int               cur_lat = 0;
  int               cur_rad = 0;
  int               fire_at = -1;
  int               n_starts = 0;
  int               n_rsp = 0;
  int               model_rr = 0;
  int               last_root = 0;
  int               last_rem = 0;
  int               last_err = 0;
  logic [31:0]      held_rsp = '0;
  logic [N_REQ-1:0] acc_mask = '0;
  int               hang_rep = 0;
  bit               fin_done = 1'b0;

  // stimulus-owned state
  int lat_cfg = 8;
  bit spur = 1'b0;
  int hang_cnt = 0;
  bit fin_req = 1'b0;

  function automatic int isqrt(int x);
    int r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  function automatic int pick(logic [N_REQ-1:0] v, int rr);
    for (int k = 0; k < N_REQ; k++) begin
      int j = (rr + k) % N_REQ;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [N_REQ-1:0] exp_rdy;
    logic [N_REQ-1:0] acc;
    exp_t e;
    int w;
    int a;
    int d;
    if (hang_cnt != hang_rep) begin
      chk("wait_bound", 32'(hang_cnt), 32'(hang_rep));
      hang_rep = hang_cnt;
    end
    if (!reset_n) begin
      chk("rst_ctrl", 32'({req_ready, sq_start, rsp_valid, rsp_err}), 32'(0));
      chk("rst_data", 32'({rsp_id, rsp_root, rsp_rem, sq_rad}), 32'(0));
      busy = 1'b0; start_due = 1'b0; rsp_seen = 1'b0;
      exp_q.delete();
      model_rr = 0; acc_mask = '0; cur_rad = 0;
      last_root = 0; last_rem = 0; last_err = 0;
    end else begin
      if (!rsp_valid)
        chk("rsp_hold_idle", 32'({rsp_root, rsp_rem, rsp_err}),
            32'({8'(last_root), 8'(last_rem), 1'(last_err)}));
      w = pick(req_valid, model_rr);
      exp_rdy = '0;
      if (!busy && w >= 0) exp_rdy[w] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      acc = req_valid & req_ready;
      acc_mask = acc;
      if (acc != 0 && !busy) begin
        a = 0;
        for (int i = N_REQ - 1; i >= 0; i--) if (acc[i]) a = i;
        d = int'(req_data[a*WIDTH +: WIDTH]);
        e.id = a;
        e.err = (lat_cfg == 0 || lat_cfg > TIMEOUT) ? 1 : 0;
        e.root = e.err ? 0 : isqrt(d);
        e.rem = e.err ? 0 : d - isqrt(d) * isqrt(d);
        e.lat = e.err ? TIMEOUT + 2 : lat_cfg + 2;
        e.acc_cyc = cyc;
        exp_q.push_back(e);
        busy = 1'b1; start_due = 1'b1; acc_cyc = cyc; cur_lat = lat_cfg; cur_rad = d;
      end
      if (sq_start) begin
        chk("start_expected", 32'(start_due), 32'(1));
        chk("start_latency", 32'(cyc - acc_cyc), 32'(1));
        chk("sq_rad", 32'(sq_rad), 32'(cur_rad));
        start_due = 1'b0;
        n_starts++;
        fire_at = (cur_lat == 0) ? -1 : cyc + cur_lat;
      end else begin
        if (start_due && cyc > acc_cyc + 1) begin
          chk("start_missing", 32'(0), 32'(1));
          start_due = 1'b0;
        end
        if (busy && cyc > acc_cyc) chk("sq_rad_hold", 32'(sq_rad), 32'(cur_rad));
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 32'(1), 32'(0));
        end else begin
          e = exp_q[0];
          if (!rsp_seen) begin
            chk("rsp_latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
            chk("rsp_id", 32'(rsp_id), 32'(e.id));
            chk("rsp_root", 32'(rsp_root), 32'(e.root));
            chk("rsp_rem", 32'(rsp_rem), 32'(e.rem));
            chk("rsp_err", 32'(rsp_err), 32'(e.err));
            held_rsp = 32'({rsp_id, rsp_root, rsp_rem, rsp_err});
            rsp_seen = 1'b1;
          end else begin
            chk("rsp_stable", 32'({rsp_id, rsp_root, rsp_rem, rsp_err}), held_rsp);
          end
          if (rsp_ready) begin
            exp_q.pop_front();
            model_rr = (e.id + 1) % N_REQ;
            last_root = e.root; last_rem = e.rem; last_err = e.err;
            busy = 1'b0; rsp_seen = 1'b0;
            n_rsp++;
          end
        end
      end
    end
    if (fin_req && !fin_done) begin
      chk("final_drained", 32'(exp_q.size() + int'(busy)), 32'(0));
      fin_done = 1'b1;
    end
  end

  // One cycle of stimulus; also acts as the sqrt unit stub
  task automatic tick();
    int r;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~acc_mask;
    sq_valid = spur || (fire_at == cyc);
    if (sq_valid && !spur) begin
      r = isqrt(int'(sq_rad));
      sq_root = WIDTH'(r);
      sq_rem = WIDTH'(int'(sq_rad) - r * r);
    end else begin
      sq_root = 8'($urandom);
      sq_rem = 8'($urandom);
    end
    sq_busy = (fire_at > cyc);
    spur = 1'b0;
  endtask

  task automatic req(int i, int d);
    req_valid[i] = 1'b1;
    req_data[i*WIDTH +: WIDTH] = WIDTH'(d);
  endtask

  task automatic wait_idle(int maxc);
    int n = 0;
    while ((req_valid != 0 || busy) && n < maxc) begin tick(); n++; end
    if (req_valid != 0 || busy) hang_cnt++;
  endtask

  task automatic wait_gone(int i, int maxc);
    int n = 0;
    while (req_valid[i] && n < maxc) begin tick(); n++; end
    if (req_valid[i]) hang_cnt++;
  endtask

  task automatic wait_rsp(int maxc);
    int n = 0;
    while (!rsp_valid && n < maxc) begin tick(); n++; end
    if (!rsp_valid) hang_cnt++;
  endtask

  initial begin
    int s0;
    int n;
    int r;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // round robin from rr_ptr = 0, requester 0 re-requests to show the wrap
    lat_cfg = 8;
    req(0, 0); req(1, 10); req(2, 100); req(3, 255);
    wait_gone(0, 50);
    req(0, 0);
    wait_idle(300);

    // single request, 8-cycle sqrt
    req(2, 49);
    wait_idle(100);

    // timeout then normal service, then the terminal-count boundary both ways
    lat_cfg = 0;  req(1, 81);  wait_idle(100);
    lat_cfg = 8;  req(1, 81);  wait_idle(100);
    lat_cfg = 16; req(3, 200); wait_idle(100);
    lat_cfg = 17; req(0, 123); wait_idle(100);

    // backpressure with a spurious sq_valid during RESP and another requester waiting
    lat_cfg = 5;
    req(0, 144);
    wait_rsp(100);
    rsp_ready = 1'b0;
    req(1, 2);
    for (int i = 0; i < 20; i++) begin
      if (i == 10) spur = 1'b1;
      tick();
    end
    rsp_ready = 1'b1;
    wait_idle(100);

    // spurious sq_valid while idle
    spur = 1'b1;
    repeat (5) tick();

    // reset three cycles after sq_start; the stub's late sq_valid must be ignored
    lat_cfg = 8;
    req(2, 64);
    s0 = n_starts;
    n = 0;
    while (n_starts == s0 && n < 50) begin tick(); n++; end
    if (n_starts == s0) hang_cnt++;
    tick(); tick();
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    repeat (8) tick();
    req(3, 9); req(1, 25);
    wait_idle(200);

    // random traffic
    for (int t = 0; t < 4000 && n_rsp < 160; t++) begin
      tick();
      for (int i = 0; i < N_REQ; i++)
        if (!req_valid[i] && $urandom_range(0, 3) == 0) req(i, int'($urandom_range(0, 255)));
      rsp_ready = ($urandom_range(0, 3) != 0);
      r = int'($urandom_range(0, 19));
      lat_cfg = (r == 19) ? 0 : r + 1;
    end
    rsp_ready = 1'b1;
    wait_idle(300);

    fin_req = 1'b1;
    tick(); tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish at cycle %0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/sd_sqrt_scheduler.md
# sd_sqrt_scheduler

Round-robin scheduler that shares one iterative square-root unit (start/busy/valid handshake, radicand in, root/remainder out) among N requesting channels, e.g. per-channel variance-to-standard-deviation conversion in the normalization stage. Accepts one radicand at a time from the winning requester and pulses the sqrt start. It holds the radicand stable until the sqrt reports valid, then returns root, remainder and requester ID on a valid/ready response port. A watchdog flags a sqrt unit that never completes.

## Interface
- WIDTH, 8: radicand/root/remainder width; passed unchanged to the sqrt unit.
- N_REQ, 4: number of requesters, 2..16.
- ID_W, $clog2(N_REQ): requester-ID width.
- TIMEOUT, 64: maximum cycles in WAIT before error abort, ≥ 2.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  per-requester request.
- req_data  in  N_REQ*WIDTH  radicands; requester i at bits [i*WIDTH +: WIDTH].
- req_ready  out  N_REQ  one-hot accept; transfer when req_valid[i] & req_ready[i].
- sq_start  out  1  one-cycle start pulse to the sqrt unit.
- sq_rad  out  WIDTH  radicand to the sqrt unit.
- sq_busy  in  1  sqrt busy; monitored only.
- sq_valid  in  1  sqrt result valid.
- sq_root  in  WIDTH  sqrt root.
- sq_rem  in  WIDTH  sqrt remainder.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  ID_W  requester index of the response.
- rsp_root  out  WIDTH  captured root.
- rsp_rem  out  WIDTH  captured remainder.
- rsp_err  out  1  response is a timeout abort; root/rem are 0.

## Operation
- FSM states: IDLE, START, WAIT, RESP.
- IDLE: if any req_valid, grant the first set bit searching upward from rr_ptr with wrap. The grant is combinational; req_ready is the one-hot grant, asserted only in IDLE.
  - On acceptance, latch req_data slice into rad_q and the index into id_q, then go to START.
  - No req_valid: stay in IDLE; req_ready = 0.
- START: sq_start = 1 for exactly this cycle, then WAIT. Clear the timeout counter.
- WAIT: on sq_valid, capture sq_root/sq_rem and clear err_q, then go to RESP. Otherwise increment the counter.
  - When the counter reaches TIMEOUT-1 without sq_valid: set err_q = 1, root/rem = 0, go to RESP.
- RESP: rsp_valid = 1; outputs stable until rsp_valid & rsp_ready. On handshake, set rr_ptr = (id_q+1) mod N_REQ and go to IDLE.
- sq_rad = rad_q at all times. It is held from START until the next acceptance.
- sq_valid outside WAIT is ignored. sq_busy does not affect state transitions.
- req_valid changes outside IDLE have no effect. Requesters must hold req_valid/req_data until accepted.
- Widths: no arithmetic on data; the ID is a zero-extended index.

## Timing
- Reset (async assert, sync-safe deassert behaviour is the integrator's concern):
  - state = IDLE, rr_ptr = 0.
  - rad_q, id_q, root/rem regs = 0; err_q = 0; counter = 0.
  - Outputs: sq_start = 0, rsp_valid = 0, req_ready = 0 while reset_n low.
- Reset mid-operation aborts immediately. No response is produced, and a late sq_valid after reset is ignored (state is IDLE).
- Sequence from acceptance at cycle t:
  - sq_start high at t+1; WAIT from t+2.
  - If sq_valid is seen in cycle w ≥ t+2, rsp_valid rises at w+1.
  - Handshake at cycle r gives IDLE at r+1; the next acceptance can occur at r+1.
  - Minimum request-to-request spacing is 4 cycles.
- Timeout: with no sq_valid, rsp_valid with rsp_err = 1 rises exactly TIMEOUT cycles after entering WAIT.
- Simultaneous sq_valid and timeout terminal count: sq_valid wins, err = 0.
- rsp_ready held low: stays in RESP indefinitely; no new requests are accepted.
- rr_ptr updates only on response handshake, including error responses.

## Test plan
- Single request: N_REQ=4, WIDTH=8, sqrt model with 8-cycle latency; req 2 presents 49.
  - sq_start pulses once with sq_rad = 49.
  - Response: rsp_id = 2, root = 7, rem = 0, err = 0, 10 cycles after acceptance.
- Round-robin: all four req_valid high with radicands 0, 10, 100, 255, rsp_ready always 1.
  - Grant order 0, 1, 2, 3, 0.
  - Responses (root,rem) = (0,0), (3,1), (10,0), (15,30).
- Backpressure: rsp_ready low for 20 cycles during RESP.
  - rsp_* stable throughout; req_ready stays 0.
  - sq_start does not pulse again until after the handshake.
- Timeout: TIMEOUT=16, sqrt model never asserts sq_valid.
  - rsp_err = 1, root = rem = 0, 16 cycles after WAIT entry.
  - Next request is serviced normally.
- Reset mid-WAIT: assert reset_n low 3 cycles after sq_start.
  - All outputs 0 immediately; rr_ptr = 0.
  - The sqrt model's subsequent sq_valid produces no response.
- Spurious sq_valid: pulse sq_valid while in IDLE and RESP.
  - No state change; rsp values unchanged.
